// File: rtl/g3f_cmd_pkg.sv
// Shared command-interface definitions for the g3f receiver and the core's command decoder.
package g3f_cmd_pkg;
  localparam int CMD_BYTES_DEF  = 3;
  localparam int CMD_W          = 8 * CMD_BYTES_DEF;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int TIMEOUT_DEF    = 255;

  typedef logic [CMD_W-1:0] cmd_t;
endpackage

// File: rtl/g3f_sync_edge.sv
// Two-flop synchronizer for an asynchronous host line, followed by a rising-edge pulse.
module g3f_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_pulse
);
  logic r_s1, r_s2, r_hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_hist <= 1'b0;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_hist <= r_s2;
    end
  end

  assign o_pulse = r_s2 & ~r_hist;
endmodule

// File: rtl/g3f_cmd_rx.sv
// Host command receiver: byte assembler with idle timeout, command FIFO and sticky error flags.
module g3f_cmd_rx
  import g3f_cmd_pkg::*;
#(
  parameter int CMD_BYTES  = CMD_BYTES_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [7:0]             ui_in,
  input  logic                   strb_in,
  input  logic                   abort_in,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [8*CMD_BYTES-1:0] cmd_data,
  output logic                   busy,
  output logic                   overflow,
  output logic                   frame_err
);
  localparam int W   = 8 * CMD_BYTES;
  localparam int BCW = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [BCW-1:0] LAST_IDX = BCW'(CMD_BYTES - 1);
  localparam logic [PW:0]    FULL_CNT = (PW + 1)'(FIFO_DEPTH);
  localparam logic [15:0]    TO_LAST  = 16'(TIMEOUT - 1);

  logic [W-1:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0]  r_rd_ptr, r_wr_ptr;
  logic [PW:0]    r_count;
  logic [W-1:0]   r_asm;
  logic [BCW-1:0] r_byte_cnt;
  logic [15:0]    r_to_cnt;
  logic           r_busy, r_overflow, r_frame_err;

  logic           w_strb_edge, w_abort_edge;
  logic           w_pop, w_timeout, w_cap, w_last, w_push, w_drop;
  logic [BCW-1:0] w_byte_cnt_nxt;
  logic [W-1:0]   w_cmd;

  g3f_sync_edge u_strb (.clk(clk), .rst(rst), .i_async(strb_in),  .o_pulse(w_strb_edge));
  g3f_sync_edge u_abort(.clk(clk), .rst(rst), .i_async(abort_in), .o_pulse(w_abort_edge));

  // Priority: abort over timeout over capture; a losing strobe edge is simply dropped.
  always_comb begin
    w_pop     = (r_count != '0) && cmd_ready;
    w_timeout = (r_byte_cnt != '0) && (r_to_cnt == TO_LAST);
    w_cap     = w_strb_edge && ena && !w_abort_edge && !w_timeout;
    w_last    = w_cap && (r_byte_cnt == LAST_IDX);
    w_push    = w_last && ((r_count != FULL_CNT) || w_pop);
    w_drop    = w_last && !w_push;

    w_cmd = r_asm;
    for (int i = 0; i < CMD_BYTES; i++) begin
      if (r_byte_cnt == BCW'(i)) w_cmd[8*(CMD_BYTES-1-i) +: 8] = ui_in;
    end

    w_byte_cnt_nxt = r_byte_cnt;
    if (w_abort_edge || w_timeout || w_last) w_byte_cnt_nxt = '0;
    else if (w_cap)                          w_byte_cnt_nxt = r_byte_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_asm       <= '0;
      r_byte_cnt  <= '0;
      r_to_cnt    <= '0;
      r_busy      <= 1'b0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_byte_cnt <= w_byte_cnt_nxt;
      r_busy     <= (w_byte_cnt_nxt != '0);

      if (w_abort_edge) begin
        r_to_cnt    <= '0;
        r_overflow  <= 1'b0;
        r_frame_err <= 1'b0;
      end else if (w_timeout) begin
        r_to_cnt    <= '0;
        r_frame_err <= 1'b1;
      end else if (w_cap) begin
        r_asm    <= w_cmd;
        r_to_cnt <= '0;
        if (w_drop) r_overflow <= 1'b1;
      end else if (r_byte_cnt != '0) begin
        r_to_cnt <= r_to_cnt + 16'd1;
      end

      if (w_push) begin
        r_mem[r_wr_ptr] <= w_cmd;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign cmd_valid = (r_count != '0);
  assign cmd_data  = r_mem[r_rd_ptr];
  assign busy      = r_busy;
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;
endmodule

// File: doc/g3f_cmd_rx.md
# g3f_cmd_rx

Host-facing command receiver sitting directly upstream of the `tt_um_g3f` core datapath. Captures bytes presented on `ui_in` under an asynchronous host strobe, assembles them into fixed-length command words, and buffers them in a small FIFO. The core drains commands over a valid/ready handshake. Sticky error flags are exported for mapping onto `uio_out`.

## Interface
Parameters:
- `CMD_BYTES`, 3: bytes per command; first byte received lands in the MSBs.
- `FIFO_DEPTH`, 4: command FIFO entries; must be a power of two, 2..16.
- `TIMEOUT`, 255: idle cycles after which a partial command is discarded; valid range 1..65535.

Ports:
- `clk`  in  1  design clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `ena`  in  1  design selected; when low, strobes are ignored.
- `ui_in`  in  8  command byte from host.
- `strb_in`  in  1  asynchronous host byte strobe (`uio_in[0]`).
- `abort_in`  in  1  asynchronous host abort (`uio_in[1]`).
- `cmd_valid`  out  1  FIFO head holds a command.
- `cmd_ready`  in  1  core accepts the head command.
- `cmd_data`  out  8*CMD_BYTES  FIFO head command.
- `busy`  out  1  partial command in progress (byte count ≠ 0).
- `overflow`  out  1  sticky: completed command dropped because FIFO was full.
- `frame_err`  out  1  sticky: partial command discarded by timeout.

## Operation
- `strb_in` and `abort_in` each pass through a 2-flop synchronizer followed by a rising-edge detector. Edge detector history resets to 0.
- Strobe edge with `ena`=1: capture `ui_in` into assembler slot `byte_cnt`, then increment `byte_cnt`. `ui_in` must be stable from strobe rise until strobe fall.
- Strobe edge with `ena`=0: ignored. Assembler and timeout state hold.
- On capture of byte `CMD_BYTES-1`:
  - `byte_cnt` returns to 0.
  - Command is pushed if FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the command is dropped and `overflow` is set.
- Pop occurs when `cmd_valid && cmd_ready`. `cmd_data` is the registered head and is stable while `cmd_valid` is high and not popped.
- Timeout counter:
  - Clears on every capture.
  - Increments each cycle while `byte_cnt` ≠ 0.
  - On reaching `TIMEOUT`: `byte_cnt` goes to 0, the partial command is discarded, and `frame_err` is set.
- Abort edge:
  - `byte_cnt` goes to 0 and the timeout counter clears.
  - `overflow` and `frame_err` clear.
  - FIFO contents are kept.
- Simultaneous abort edge and strobe edge: abort wins and the byte is discarded.
- Simultaneous timeout and strobe edge: timeout wins.
- Reset values: `cmd_valid`=0, `cmd_data`=0, `busy`=0, `overflow`=0, `frame_err`=0. FIFO empty, `byte_cnt`=0, synchronizers 0.
- Reset mid-command or with FIFO occupied discards everything. Nothing is flushed.

## Timing
- Edge E is the first `clk` edge sampling `strb_in`=1.
- Edge E+1: second synchronizer flop high; edge detector fires combinationally.
- Edge E+2: byte captured. For the last byte, the FIFO is written and `cmd_valid` is high from E+2 (FIFO was empty).
- Total latency, strobe to `cmd_valid`: 3 edges.
- Minimum strobe high and low time: 3 `clk` periods each. Maximum byte rate: one per 6 cycles.
- Pop takes effect at the clock edge where `cmd_valid && cmd_ready`. The next head appears at `cmd_data` in the following cycle, with no bubble.
- `busy` is registered and follows `byte_cnt` with no added delay.
- FIFO pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. Count is one bit wider; full is count == `FIFO_DEPTH`.

## Structure
- Package `g3f_cmd_pkg` holds:
  - `CMD_W` localparam (8*CMD_BYTES).
  - The `cmd_t` packed typedef.
  - Default `FIFO_DEPTH` and `TIMEOUT` constants.
  - The same package is shared with the core's command decoder.
- Sub-module `g3f_sync_edge` (2-flop synchronizer plus rising-edge pulse, synchronous active-high reset), instantiated for strobe and abort.
- FIFO, assembler, and timeout counter are inline in `g3f_cmd_rx`.

## Test plan
- Reset, then 3 strobes with bytes 0xA1, 0xB2, 0xC3 and `cmd_ready`=0 → `cmd_valid`=1 3 edges after the third strobe; `cmd_data`=0xA1B2C3; `busy` high from first capture through third capture.
- 5 commands with `cmd_ready`=0, then drain:
  - 4 commands received.
  - `overflow`=1 after the 5th.
  - Drained in order with `cmd_ready`=1, back-to-back with no bubble.
- Full FIFO, last byte of a new command captured in the same cycle as a pop → accepted; `overflow` stays 0; count stays 4.
- 2 bytes, then idle `TIMEOUT` cycles → `busy`=0 and `frame_err`=1. A following 3-byte command 0x010203 is received intact.
- Abort and strobe edges in the same cycle mid-command → byte discarded; `byte_cnt`=0; sticky flags cleared.
- `ena`=0 during strobes → nothing captured. Assert `rst` with 2 commands queued → `cmd_valid`=0 and all outputs 0 the next cycle.
